// File: rtl/rom_arbiter_pkg.sv
// Shared defaults and helpers for the ROM arbiter and its round-robin picker.
package rom_arb_pkg;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_ADDR_W  = 12;
    localparam int DEF_DATA_W  = 12;
    localparam int DEF_ROM_LAT = 1;

    // Requester ID width; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// Requester-side and ROM-side bus of the ROM arbiter.
interface rom_arbiter_if
    import rom_arb_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] addr;
    logic [N_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]       rom_addr;
    logic [DATA_W-1:0]       rom_data;
    logic [N_REQ-1:0]        rd_valid;
    logic [DATA_W-1:0]       rd_data;

    modport slave (
        input  req, addr, rom_data,
        output gnt, rom_addr, rd_valid, rd_data
    );

    modport master (
        output req, addr, rom_data,
        input  gnt, rom_addr, rd_valid, rd_data
    );

endinterface

// File: rtl/rom_arbiter_rr_pick.sv
// Combinational round-robin find-first: the first set req at or after ptr wins.
module rr_pick
    import rom_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int ID_W  = id_width(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  win_o,
    output logic             any_o
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [2*N_REQ-1:0] gnt_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [N_REQ-1:0]   first_rot;

    // Rotate so the pointed-to requester sits at bit 0, pick, rotate back.
    assign req_dbl = {req_i, req_i} >> ptr_i;
    assign req_rot = req_dbl[N_REQ-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_first
            if (gi == 0) begin : g_lsb
                assign first_rot[gi] = req_rot[gi];
            end else begin : g_rest
                assign first_rot[gi] = req_rot[gi] & ~(|req_rot[gi-1:0]);
            end
        end
    endgenerate

    assign gnt_dbl = {first_rot, first_rot} << ptr_i;
    assign gnt_o   = gnt_dbl[2*N_REQ-1:N_REQ];
    assign any_o   = |req_i;

    always_comb begin
        win_o = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt_o[k]) begin
                win_o = ID_W'(k);
            end
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin sharing of one synchronous ROM among N_REQ requesters, with a
// valid/ID tag pipeline that steers each returning word back to its requester.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ROM_LAT = DEF_ROM_LAT
) (
    input  logic          clk,
    input  logic          rst,
    rom_arbiter_if.slave  bus
);

    localparam int ID_W  = id_width(N_REQ);
    // One stage for the rom_addr register plus the ROM's own latency.
    localparam int DEPTH = 1 + ROM_LAT;

    logic [ADDR_W-1:0] addr_arr [N_REQ];
    logic [N_REQ-1:0]  pick_gnt;
    logic [ID_W-1:0]   win;
    logic              any;

    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [ID_W-1:0]   id_q [DEPTH];
    logic [ID_W-1:0]   id_d [DEPTH];
    logic [N_REQ-1:0]  rd_valid;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_addr
            assign addr_arr[gi] = bus.addr[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .win_o (win),
        .any_o (any)
    );

    always_comb begin
        ptr_d      = ptr_q;
        rom_addr_d = rom_addr_q;
        vld_d      = {vld_q[DEPTH-2:0], any};
        id_d[0]    = win;
        for (int s = 1; s < DEPTH; s++) begin
            id_d[s] = id_q[s-1];
        end
        if (any) begin
            ptr_d      = (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
            rom_addr_d = addr_arr[win];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            rom_addr_q <= '0;
            vld_q      <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                id_q[s] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            rom_addr_q <= rom_addr_d;
            vld_q      <= vld_d;
            for (int s = 0; s < DEPTH; s++) begin
                id_q[s] <= id_d[s];
            end
        end
    end

    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rd_valid
            assign rd_valid[gi] = vld_q[DEPTH-1] & (id_q[DEPTH-1] == ID_W'(gi));
        end
    endgenerate

    assign bus.gnt      = rst ? '0 : pick_gnt;
    assign bus.rom_addr = rom_addr_q;
    assign bus.rd_valid = rd_valid;
    assign bus.rd_data  = bus.rom_data;

endmodule

// File: tb/tb_rom_arbiter.sv
// Randomized and directed bench for rom_arbiter against a queue-based reference model.
module tb_rom_arbiter;
    import rom_arb_pkg::*;

    localparam int N   = 4;
    localparam int AW  = 12;
    localparam int DW  = 12;
    localparam int LAT = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rom_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        logic [31:0] p;
        p = {20'd0, a} * 32'd13;
        return p[DW-1:0] ^ 12'hA5C;
    endfunction

    // Synchronous ROM with a registered output (one-cycle read).
    always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_addr);

    logic [N-1:0]  req_v;
    logic [AW-1:0] addr_v [N];
    logic [N-1:0]  last_gnt;
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic drive();
        bus.req = req_v;
        for (int i = 0; i < N; i++) bus.addr[i*AW +: AW] = addr_v[i];
    endtask

    task automatic sample();
        @(negedge clk);
        last_gnt = bus.gnt & bus.req;
    endtask

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    // Reference model: priority pointer, registered address, and a queue of reads in flight.
    typedef struct { int due; int id; logic [AW-1:0] a; } rd_t;
    rd_t pend[$];
    int m_ptr = 0;
    int m_w;
    logic [AW-1:0] m_rom_addr = '0;
    logic [N-1:0] m_eg, m_ev;
    logic [DW-1:0] m_ed;

    always @(negedge clk) begin
        cyc++;
        m_w = -1;
        if (rst) begin
            pend.delete();
            m_ptr = 0;
            m_rom_addr = '0;
        end else begin
            for (int k = N - 1; k >= 0; k--)
                if (bus.req[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
        end
        m_eg = (m_w < 0) ? '0 : N'(1) << m_w;
        m_ev = '0;
        m_ed = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            m_ev = N'(1) << pend[0].id;
            m_ed = rom_fn(pend[0].a);
            void'(pend.pop_front());
        end
        check("gnt", 32'(bus.gnt), 32'(m_eg));
        check("rd_valid", 32'(bus.rd_valid), 32'(m_ev));
        if (m_ev != '0) check("rd_data", 32'(bus.rd_data), 32'(m_ed));
        check("rom_addr", 32'(bus.rom_addr), 32'(m_rom_addr));
        if (m_w >= 0) begin
            m_ptr = (m_w + 1) % N;
            m_rom_addr = bus.addr[m_w*AW +: AW];
            pend.push_back('{cyc + 1 + LAT, m_w, bus.addr[m_w*AW +: AW]});
        end
    end

    task automatic rand_run(input int n, input int pct);
        for (int c = 0; c < n; c++) begin
            edge_();
            rst = ($urandom_range(199) == 0);
            for (int i = 0; i < N; i++) begin
                if (last_gnt[i]) req_v[i] = 1'b0;
                if (!req_v[i] && $urandom_range(99) < pct) begin
                    req_v[i]  = 1'b1;
                    addr_v[i] = AW'($urandom);
                end
            end
            drive();
            sample();
        end
        edge_();
        rst = 1'b0;
        sample();
    endtask

    logic [N-1:0] gseq [16];
    logic [N-1:0] rseq [16];
    int pat [11] = '{1, -1, 3, -1, 1, -1, -1, 3, -1, -1, -1};
    logic [N-1:0] e;

    initial begin
        rst = 1'b1;
        req_v = '0;
        last_gnt = '0;
        for (int i = 0; i < N; i++) addr_v[i] = '0;
        drive();
        sample();
        edge_();
        // Put reads in flight, then reset with everyone requesting.
        rst = 1'b0;
        req_v = '1;
        for (int i = 0; i < N; i++) addr_v[i] = AW'(16 * i + 1);
        drive();
        sample();
        repeat (2) begin edge_(); sample(); end
        edge_();
        rst = 1'b1;
        for (int r = 0; r < 2; r++) begin
            sample();
            check("rst_gnt", 32'(bus.gnt), 32'h0);
            check("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
            check("rst_rom_addr", 32'(bus.rom_addr), 32'h0);
            edge_();
        end
        rst = 1'b0;
        // Full contention for 8 cycles.
        for (int k = 0; k < 10; k++) begin
            if (k == 8) begin req_v = '0; drive(); end
            sample();
            gseq[k] = bus.gnt;
            rseq[k] = bus.rd_valid;
            edge_();
        end
        check("first_gnt_after_rst", 32'(gseq[0]), 32'h1);
        check("no_stale_rd0", 32'(rseq[0]), 32'h0);
        check("no_stale_rd1", 32'(rseq[1]), 32'h0);
        for (int k = 0; k < 8; k++) begin
            e = N'(1) << (k % N);
            check("contention_gnt", 32'(gseq[k]), 32'(e));
            if (k < 8) begin
                sample(); edge_();
            end
        end
        for (int k = 0; k < 8; k++) begin
            e = N'(1) << (k % N);
            if (k + 2 < 10) check("contention_rd", 32'(rseq[k+2]), 32'(e));
        end
        // Single requester 2 at 0x123.
        req_v = 4'b0100;
        addr_v[2] = 12'h123;
        drive();
        sample();
        check("single_gnt", 32'(bus.gnt), 32'h4);
        edge_();
        req_v = '0;
        drive();
        sample();
        edge_();
        sample();
        check("single_rd_valid", 32'(bus.rd_valid), 32'h4);
        check("single_rd_data", 32'(bus.rd_data), 32'h49B);
        edge_();
        // Pointer now 3: wrap to 0, then skip to 2.
        req_v = 4'b0101;
        addr_v[0] = 12'h0AA;
        addr_v[2] = 12'h055;
        drive();
        sample();
        check("wrap_gnt0", 32'(bus.gnt), 32'h1);
        edge_();
        req_v = 4'b0100;
        drive();
        sample();
        check("skip_gnt2", 32'(bus.gnt), 32'h4);
        edge_();
        req_v = '0;
        drive();
        sample();
        edge_();
        // Idle gaps between requesters 1 and 3.
        for (int k = 0; k < 11; k++) begin
            req_v = '0;
            if (pat[k] >= 0) begin
                req_v[pat[k]] = 1'b1;
                addr_v[pat[k]] = AW'(12'h300 + k);
            end
            drive();
            sample();
            rseq[k] = bus.rd_valid;
            edge_();
        end
        for (int k = 0; k < 9; k++) begin
            e = (pat[k] >= 0) ? N'(1) << pat[k] : '0;
            check("gap_rd_valid", 32'(rseq[k+2]), 32'(e));
        end
        // Reset one cycle after two transfers.
        req_v = '1;
        drive();
        sample();
        edge_();
        sample();
        edge_();
        rst = 1'b1;
        sample();
        check("midrst_rd_valid", 32'(bus.rd_valid), 32'h0);
        edge_();
        rst = 1'b0;
        sample();
        check("midrst_restart_gnt", 32'(bus.gnt), 32'h1);
        check("midrst_discard", 32'(bus.rd_valid), 32'h0);
        edge_();
        req_v = '0;
        drive();
        sample();
        // Randomized traffic at several densities.
        rand_run(300, 30);
        rand_run(300, 85);
        rand_run(200, 8);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
